beep_melody_sequencer: RTL

- Plays a fixed tune on the PWM beeper. Steps through an internal 16-entry melody ROM and drives `period`/`pulse` of the PWM generator, which runs at prescaler 2, i.e. a 25 MHz count clock.
- Outputs a `mute` gate that the top level ANDs with the generator output for rests and inter-note gaps.
- Sits between the key/control logic and the PWM generator in the beep design.

---
 rtl/beep_melody_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/beep_melody_sequencer.sv
// Melody sequencer for the PWM beeper.
// Steps through a 16-entry melody ROM, loads period/pulse for each tone,
// and gates the beeper with `mute` during rests and the short articulation
// gap that follows every note. Every output comes straight from a register.
module beep_melody_sequencer #(
  parameter int unsigned BEAT_CYCLES = 12_500_000,  // sclk cycles per beat
  parameter int unsigned GAP_CYCLES  = 500_000,     // muted cycles after each note
  parameter int unsigned DUTY_SHIFT  = 1            // pulse = period >> DUTY_SHIFT
) (
  input  logic        sclk,
  input  logic        nrst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [25:0] period,
  output logic [25:0] pulse,
  output logic        mute,
  output logic        busy,
  output logic        done,
  output logic [3:0]  note_idx,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [25:0] RESET_PERIOD = 26'd95556;
  localparam logic [25:0] RESET_PULSE  = RESET_PERIOD >> DUTY_SHIFT;

  // Melody ROM entry = {note code, beats}; beats == 0 marks the end.
  function automatic logic [7:0] rom_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_entry = {4'd1, 4'd2};
      4'd1:    rom_entry = {4'd2, 4'd2};
      4'd2:    rom_entry = {4'd3, 4'd2};
      4'd3:    rom_entry = {4'd4, 4'd2};
      4'd4:    rom_entry = {4'd5, 4'd2};
      4'd5:    rom_entry = {4'd6, 4'd2};
      4'd6:    rom_entry = {4'd7, 4'd2};
      4'd7:    rom_entry = {4'd0, 4'd1};
      4'd8:    rom_entry = {4'd5, 4'd4};
      default: rom_entry = 8'h00;
    endcase
  endfunction

  // Note code to PWM period at the 25 MHz count clock; 0 means rest.
  function automatic logic [25:0] tone_period(input logic [3:0] code);
    case (code)
      4'd1:    tone_period = 26'd95556;  // C4
      4'd2:    tone_period = 26'd85133;  // D4
      4'd3:    tone_period = 26'd75843;  // E4
      4'd4:    tone_period = 26'd71586;  // F4
      4'd5:    tone_period = 26'd63776;  // G4
      4'd6:    tone_period = 26'd56818;  // A4
      4'd7:    tone_period = 26'd50620;  // B4
      default: tone_period = 26'd0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [25:0] period_q, period_d;
  logic [25:0] pulse_q, pulse_d;
  logic        mute_q, mute_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] dur_q, dur_d;
  logic [31:0] gap_q, gap_d;

  logic [7:0]  entry;
  logic [3:0]  beats;
  logic [25:0] tone;
  state_t      adv_state;
  logic [3:0]  adv_idx;

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    period_d = period_q;
    pulse_d  = pulse_q;
    mute_d   = mute_q;
    dur_d    = dur_q;
    gap_d    = gap_q;

    entry = rom_entry(idx_q);
    beats = entry[3:0];
    tone  = tone_period(entry[7:4]);

    // Moving past a finished note: the last ROM slot behaves like an end marker.
    adv_state = S_LOAD;
    adv_idx   = idx_q + 4'd1;
    if (idx_q == 4'd15) begin
      if (loop_en) begin
        adv_idx = 4'd0;
      end else begin
        adv_idx   = idx_q;
        adv_state = S_DONE;
      end
    end

    case (state_q)
      S_IDLE: begin
        mute_d = 1'b1;
        if (start) begin
          idx_d   = 4'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (beats != 4'd0) begin
          state_d = S_PLAY;
          dur_d   = 32'(beats) * BEAT_CYCLES - 32'd1;
          if (tone != 26'd0) begin
            period_d = tone;
            pulse_d  = tone >> DUTY_SHIFT;
            mute_d   = 1'b0;
          end else begin
            mute_d = 1'b1;
          end
        end else if (loop_en && (idx_q != 4'd0)) begin
          idx_d = 4'd0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PLAY: begin
        if (dur_q == 32'd0) begin
          mute_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_CYCLES - 32'd1;
            state_d = S_GAP;
          end else begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end
        end else begin
          dur_d = dur_q - 32'd1;
        end
      end
      S_GAP: begin
        mute_d = 1'b1;
        if (gap_q == 32'd0) begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      S_DONE: begin
        mute_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        mute_d  = 1'b1;
      end
    endcase

    // Stop aborts from anywhere and beats a simultaneous start; tone registers hold.
    if (stop) begin
      state_d  = S_IDLE;
      idx_d    = 4'd0;
      mute_d   = 1'b1;
      period_d = period_q;
      pulse_d  = pulse_q;
      dur_d    = 32'd0;
      gap_d    = 32'd0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      period_q <= RESET_PERIOD;
      pulse_q  <= RESET_PULSE;
      mute_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dur_q    <= 32'd0;
      gap_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      period_q <= period_d;
      pulse_q  <= pulse_d;
      mute_q   <= mute_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dur_q    <= dur_d;
      gap_q    <= gap_d;
    end
  end

  assign period    = period_q;
  assign pulse     = pulse_q;
  assign mute      = mute_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign note_idx  = idx_q;
  assign state_dbg = state_q;

endmodule
